// File: rtl/accum_frame_reader_if.sv
// Bundle between the frame reader, the accumulator FIFO read side and the TX path.
// master: the reader (pops FIFO, drives bytes/status); slave: FIFO + transmitter side.
interface accum_frame_reader_if;
   logic        fifo_empty;
   logic [15:0] fifo_data;
   logic        fifo_rd;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        frame_busy;
   logic        frame_done;
   logic        err_underrun;

   modport master (
      input  fifo_empty,
      input  fifo_data,
      input  tx_ready,
      output fifo_rd,
      output tx_data,
      output tx_valid,
      output frame_busy,
      output frame_done,
      output err_underrun
   );

   modport slave (
      output fifo_empty,
      output fifo_data,
      output tx_ready,
      input  fifo_rd,
      input  tx_data,
      input  tx_valid,
      input  frame_busy,
      input  frame_done,
      input  err_underrun
   );
endinterface

// File: rtl/accum_frame_reader.sv
// Drains the FWFT accumulator FIFO and frames words as: header, payload
// (MSB byte first), modulo-256 payload checksum; bytes leave on a valid/ready
// handshake. Ports: clk, rst (sync, active-high), bus (master modport):
// fifo_empty/fifo_data in, fifo_rd out (combinational pop strobe),
// tx_data/tx_valid out, tx_ready in, frame_busy, frame_done, err_underrun out.
module accum_frame_reader #(
   parameter int         WORDS_PER_FRAME = 125,
   parameter logic [7:0] HEADER_BYTE     = 8'hA5,
   parameter int         TIMEOUT_CYCLES  = 65535
) (
   input logic                  clk,
   input logic                  rst,
   accum_frame_reader_if.master bus
);

   typedef enum logic [2:0] {
      IDLE,
      HEADER,
      WAIT_WORD,
      SEND_HI,
      SEND_LO,
      SEND_CSUM,
      DONE
   } state_t;

   localparam int CW =
      (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1;
   localparam logic [CW-1:0] LAST_WORD = CW'(WORDS_PER_FRAME - 1);
   localparam logic [15:0]   TO_LAST   = 16'(TIMEOUT_CYCLES - 1);

   state_t        state;
   logic [7:0]    loByte;
   logic [7:0]    csum;
   logic [CW-1:0] wordCnt;
   logic [15:0]   toCnt;
   logic          padding;
   logic [7:0]    txData;
   logic          txValid;
   logic          busy;
   logic          done;
   logic          errUnd;

   logic accept;
   logic take;

   assign accept = txValid & bus.tx_ready;
   // Once padding starts the FIFO is left alone for the rest of the frame.
   assign take = (state == WAIT_WORD) & ~bus.fifo_empty & ~padding;

   assign bus.fifo_rd      = take;
   assign bus.tx_data      = txData;
   assign bus.tx_valid     = txValid;
   assign bus.frame_busy   = busy;
   assign bus.frame_done   = done;
   assign bus.err_underrun = errUnd;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         loByte  <= 8'h00;
         csum    <= 8'h00;
         wordCnt <= '0;
         toCnt   <= 16'h0000;
         padding <= 1'b0;
         txData  <= 8'h00;
         txValid <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         errUnd  <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (~bus.fifo_empty) begin
                  txData  <= HEADER_BYTE;
                  txValid <= 1'b1;
                  busy    <= 1'b1;
                  csum    <= 8'h00;
                  wordCnt <= '0;
                  toCnt   <= 16'h0000;
                  state   <= HEADER;
               end
            end
            HEADER: begin
               if (accept) begin
                  txValid <= 1'b0;
                  state   <= WAIT_WORD;
               end
            end
            WAIT_WORD: begin
               if (padding) begin
                  loByte  <= 8'h00;
                  txData  <= 8'h00;
                  txValid <= 1'b1;
                  toCnt   <= 16'h0000;
                  state   <= SEND_HI;
               end else if (~bus.fifo_empty) begin
                  // High byte goes straight out; only the low byte is kept.
                  loByte  <= bus.fifo_data[7:0];
                  txData  <= bus.fifo_data[15:8];
                  txValid <= 1'b1;
                  toCnt   <= 16'h0000;
                  state   <= SEND_HI;
               end else begin
                  toCnt <= toCnt + 16'd1;
                  if (toCnt == TO_LAST) begin
                     padding <= 1'b1;
                     errUnd  <= 1'b1;
                  end
               end
            end
            SEND_HI: begin
               if (accept) begin
                  csum   <= csum + txData;
                  txData <= loByte;
                  state  <= SEND_LO;
               end
            end
            SEND_LO: begin
               if (accept) begin
                  csum    <= csum + txData;
                  wordCnt <= wordCnt + 1'b1;
                  if (wordCnt == LAST_WORD) begin
                     // Checksum byte folds in the low byte being accepted now.
                     txData <= csum + txData;
                     state  <= SEND_CSUM;
                  end else begin
                     txValid <= 1'b0;
                     state   <= WAIT_WORD;
                  end
               end
            end
            SEND_CSUM: begin
               if (accept) begin
                  txValid <= 1'b0;
                  done    <= 1'b1;
                  state   <= DONE;
               end
            end
            DONE: begin
               busy    <= 1'b0;
               padding <= 1'b0;
               state   <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_accum_frame_reader.sv
// Directed bench for accum_frame_reader: FIFO model, byte scoreboard,
// handshake and framing checks over normal, stalled, underrun and reset cases.
`timescale 1ns/1ps
module tb_accum_frame_reader;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   accum_frame_reader_if ifc ();

   accum_frame_reader #(
      .WORDS_PER_FRAME (125),
      .HEADER_BYTE     (8'hA5),
      .TIMEOUT_CYCLES  (100)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc.master)
   );

   int compared   = 0;
   int mismatched = 0;

   logic [7:0]  expQ [$];
   logic [15:0] fq [$];

   bit         popPend   = 0;
   int         rdCnt     = 0;
   int         doneCnt   = 0;
   int         cyc       = 0;
   int         readyMode = 0;
   int         rdyPhase  = 0;
   int         bif       = 0;
   int         csumCyc   = -1;
   int         gapIdle   = -1;
   bit         prevValid = 0;
   bit         prevStall = 0;
   bit         prevDone  = 0;
   logic [7:0] prevData  = 8'h00;

   task automatic check(input string tag, input int obs, input int exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic expHdr();
      expQ.push_back(8'hA5);
   endtask

   task automatic expWord(input logic [15:0] w);
      expQ.push_back(w[15:8]);
      expQ.push_back(w[7:0]);
   endtask

   task automatic expCsum(input logic [7:0] c);
      expQ.push_back(c);
   endtask

   task automatic waitDone(input int target, input int budget,
                           input string tag);
      int n;
      n = 0;
      while (doneCnt < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_timeout"}, int'(doneCnt >= target), 1);
      @(negedge clk);
   endtask

   // FIFO model: sole writer of the FIFO-side interface signals.
   always @(negedge clk) begin
      if (popPend) begin
         if (fq.size() != 0) void'(fq.pop_front());
         popPend = 0;
      end
      ifc.fifo_empty = (fq.size() == 0);
      ifc.fifo_data  = (fq.size() != 0) ? fq[0] : 16'h0000;
   end

   // Transmitter ready pattern: always, or one cycle in three.
   always @(negedge clk) begin
      if (readyMode == 0) ifc.tx_ready = 1'b1;
      else ifc.tx_ready = (rdyPhase == 0);
      rdyPhase = (rdyPhase + 1) % 3;
   end

   // Monitor samples just before each rising edge.
   always @(negedge clk) begin
      #4;
      cyc++;
      if (ifc.fifo_rd) begin
         check("rd_not_empty", int'(ifc.fifo_empty), 0);
         popPend = 1;
         rdCnt++;
      end
      if (!rst) begin
         if (prevStall) begin
            check("hold_valid", int'(ifc.tx_valid), 1);
            check("hold_data", int'(ifc.tx_data), int'(prevData));
         end
         if (ifc.tx_valid && !prevValid && bif == 0) begin
            check("busy_at_hdr", int'(ifc.frame_busy), 1);
            if (csumCyc >= 0) gapIdle = cyc - csumCyc - 1;
         end
         if (ifc.tx_valid && ifc.tx_ready) begin
            check("exp_avail", int'(expQ.size() != 0), 1);
            if (expQ.size() != 0)
               check($sformatf("byte%0d", bif), int'(ifc.tx_data),
                     int'(expQ.pop_front()));
            if (bif == 251) begin
               csumCyc = cyc;
               bif = 0;
            end else begin
               bif++;
            end
         end
         if (ifc.frame_done) begin
            check("done_pulse", int'(prevDone), 0);
            doneCnt++;
         end
         prevStall = ifc.tx_valid & ~ifc.tx_ready;
         prevData  = ifc.tx_data;
         prevValid = ifc.tx_valid;
         prevDone  = ifc.frame_done;
      end else begin
         bif       = 0;
         prevStall = 0;
         prevValid = 0;
         prevDone  = 0;
         csumCyc   = -1;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int r0;
      int d0;
      int n;

      rst = 1'b1;
      repeat (3) @(negedge clk);
      #4;
      check("rst_valid", int'(ifc.tx_valid), 0);
      check("rst_data", int'(ifc.tx_data), 0);
      check("rst_rd", int'(ifc.fifo_rd), 0);
      check("rst_busy", int'(ifc.frame_busy), 0);
      check("rst_done", int'(ifc.frame_done), 0);
      check("rst_err", int'(ifc.err_underrun), 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Frame of 1..125, ready always high.
      r0 = rdCnt;
      d0 = doneCnt;
      expHdr();
      for (int i = 1; i <= 125; i++) begin
         fq.push_back(16'(i));
         expWord(16'(i));
      end
      expCsum(8'hC3);
      waitDone(d0 + 1, 3000, "t1");
      check("t1_rd", rdCnt - r0, 125);
      check("t1_done", doneCnt - d0, 1);
      check("t1_err", int'(ifc.err_underrun), 0);
      check("t1_left", expQ.size(), 0);

      // Same data, ready one cycle in three.
      readyMode = 1;
      r0 = rdCnt;
      d0 = doneCnt;
      expHdr();
      for (int i = 1; i <= 125; i++) begin
         fq.push_back(16'(i));
         expWord(16'(i));
      end
      expCsum(8'hC3);
      waitDone(d0 + 1, 5000, "t2");
      check("t2_rd", rdCnt - r0, 125);
      check("t2_done", doneCnt - d0, 1);
      check("t2_left", expQ.size(), 0);
      readyMode = 0;
      @(negedge clk);

      // Negative first word, zeros after.
      r0 = rdCnt;
      d0 = doneCnt;
      expHdr();
      fq.push_back(16'hFF80);
      expWord(16'hFF80);
      for (int i = 2; i <= 125; i++) begin
         fq.push_back(16'h0000);
         expWord(16'h0000);
      end
      expCsum(8'h7F);
      waitDone(d0 + 1, 3000, "t3");
      check("t3_rd", rdCnt - r0, 125);
      check("t3_left", expQ.size(), 0);

      // Reset during the low byte of word 40.
      r0 = rdCnt;
      d0 = doneCnt;
      expHdr();
      for (int i = 1; i <= 125; i++) fq.push_back(16'(i));
      for (int i = 1; i <= 39; i++) expWord(16'(i));
      expQ.push_back(8'h00);
      n = 0;
      while (bif < 80 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("t5_reach_w40", int'(bif >= 80), 1);
      rst = 1'b1;
      @(negedge clk);
      #4;
      check("t5_valid_low", int'(ifc.tx_valid), 0);
      check("t5_busy_low", int'(ifc.frame_busy), 0);
      check("t5_sent", expQ.size(), 0);
      @(negedge clk);
      expQ.delete();
      expHdr();
      for (int i = 126; i <= 165; i++) fq.push_back(16'(i));
      for (int i = 41; i <= 165; i++) expWord(16'(i));
      expCsum(8'h4B);
      rst = 1'b0;
      waitDone(d0 + 1, 3000, "t5");
      check("t5_done", doneCnt - d0, 1);
      check("t5_rd", rdCnt - r0, 165);
      check("t5_fifo_drained", fq.size(), 0);
      check("t5_left", expQ.size(), 0);

      // Two back-to-back frames.
      r0 = rdCnt;
      d0 = doneCnt;
      gapIdle = -1;
      expHdr();
      for (int i = 1; i <= 125; i++) expWord(16'(i));
      expCsum(8'hC3);
      expHdr();
      for (int i = 126; i <= 250; i++) expWord(16'(i));
      expCsum(8'hCC);
      for (int i = 1; i <= 250; i++) fq.push_back(16'(i));
      waitDone(d0 + 2, 3000, "t6");
      check("t6_rd", rdCnt - r0, 250);
      check("t6_done", doneCnt - d0, 2);
      check("t6_gap", gapIdle, 2);
      check("t6_left", expQ.size(), 0);

      // Underrun: 10 words then padding.
      r0 = rdCnt;
      d0 = doneCnt;
      expHdr();
      for (int i = 1; i <= 10; i++) begin
         fq.push_back(16'h0010);
         expWord(16'h0010);
      end
      for (int i = 11; i <= 125; i++) expWord(16'h0000);
      expCsum(8'hA0);
      waitDone(d0 + 1, 3000, "t4");
      check("t4_rd", rdCnt - r0, 10);
      check("t4_done", doneCnt - d0, 1);
      check("t4_err", int'(ifc.err_underrun), 1);
      check("t4_left", expQ.size(), 0);
      repeat (5) @(negedge clk);
      check("t4_err_sticky", int'(ifc.err_underrun), 1);
      rst = 1'b1;
      @(negedge clk);
      #4;
      check("t4_err_clr", int'(ifc.err_underrun), 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule

// File: doc/accum_frame_reader.md
Name: accum_frame_reader

Overview:
- Drains the 16-bit accumulated-waveform FIFO (fast-to-slow FIFO, first-word-fall-through) on the slow clock domain.
- Frames words into fixed-length packets: header byte, payload (each word MSB byte first), 8-bit checksum trailer.
- Feeds bytes to the UART transmitter over a valid/ready byte handshake.
- Sits between the accumulator FIFO read side (empty / data / read strobe) and the serial TX path.

Parameters:
- WORDS_PER_FRAME, 125, payload words per frame; must equal the accumulator per-event sample count.
- HEADER_BYTE, 8'hA5, first byte of every frame.
- TIMEOUT_CYCLES, 65535, consecutive empty cycles mid-frame before underrun padding starts; range 1..65535.

Ports:
- clk  in  1  slow clock; same clock as FIFO read side.
- rst  in  1  reset, synchronous, active-high; clock clk.
- fifo_empty  in  1  FIFO empty flag; FWFT, fifo_data valid whenever low.
- fifo_data  in  16  FIFO head word, signed two's complement, passed through unmodified.
- fifo_rd  out  1  pop strobe, one cycle per consumed word.
- tx_data  out  8  byte to transmitter.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  transmitter accepts byte when tx_valid & tx_ready.
- frame_busy  out  1  high from header issue to checksum acceptance.
- frame_done  out  1  one-cycle pulse, cycle after checksum accepted.
- err_underrun  out  1  sticky; set when a frame was padded; cleared only by rst.

Behaviour:
- Reset: state IDLE; tx_valid=0, tx_data=0, fifo_rd=0, frame_busy=0, frame_done=0, err_underrun=0; word counter, checksum, timeout counter = 0. Reset mid-frame abandons the frame; popped words are lost; tx_valid low the cycle after rst is sampled.
- All outputs registered except fifo_rd, which is combinational: fifo_rd = (state==WAIT_WORD) & ~fifo_empty & ~padding.
- States:
  - IDLE: if ~fifo_empty -> HEADER; tx_data<=HEADER_BYTE, tx_valid<=1, frame_busy<=1, checksum<=0, word_cnt<=0.
  - HEADER: hold until accept -> WAIT_WORD, tx_valid<=0.
  - WAIT_WORD: if ~fifo_empty: word_reg<=fifo_data, fifo_rd=1 -> SEND_HI. Else timeout_cnt increments; when it reaches TIMEOUT_CYCLES: padding<=1, err_underrun<=1. If padding: word_reg<=0, no pop -> SEND_HI. timeout_cnt clears on every word taken.
  - SEND_HI: tx_data=word_reg[15:8], valid; on accept checksum+=byte -> SEND_LO.
  - SEND_LO: tx_data=word_reg[7:0]; on accept checksum+=byte, word_cnt+=1; if word_cnt==WORDS_PER_FRAME-1 -> SEND_CSUM else WAIT_WORD.
  - SEND_CSUM: tx_data=checksum; on accept -> DONE.
  - DONE: frame_done=1 for one cycle, frame_busy<=0, padding<=0 -> IDLE.
- Checksum: modulo-256 sum of all payload bytes; header excluded; padded zero bytes included (contribute 0).
- Handshake: tx_data stable while tx_valid & ~tx_ready; tx_valid never drops without acceptance except on rst; no combinational path from tx_ready to tx_valid/tx_data.
- Latency: IDLE with fifo_empty low -> tx_valid high next cycle. With tx_ready held high: 2 cycles per word byte plus 1 WAIT_WORD cycle per word; frame length 2*WORDS_PER_FRAME+2 bytes.
- Padding stays active for the rest of the frame; no further FIFO pops in that frame, even if data arrives.
- Back-to-back frames: the next frame starts from IDLE the cycle after DONE.
- fifo_rd is never asserted while fifo_empty=1.

Test Plan:
- 125 words 0x0001..0x007D preloaded, tx_ready=1 -> 252 bytes: A5, 00 01 ... 00 7D, checksum 0xC3; 125 fifo_rd pulses; one frame_done; err_underrun=0.
- Same data, tx_ready high 1 cycle in 3 -> identical byte sequence; tx_data never changes while tx_valid & ~tx_ready.
- Single frame with word 0xFF80 first, rest 0x0000 -> bytes A5 FF 80 00 00 ... , checksum 0x7F.
- TIMEOUT_CYCLES=100, only 10 words 0x0010 supplied -> after 100 empty cycles, 115 words padded as 00 00; checksum 0xA0; exactly 10 fifo_rd pulses; err_underrun=1 until rst.
- rst asserted during SEND_LO of word 40 -> tx_valid=0, frame_busy=0 next cycle; no frame_done; next frame begins with A5 using the next FIFO word.
- 250 words preloaded -> two complete frames; second A5 presented 2 cycles after first checksum accepted; 250 fifo_rd pulses total.
